// File: rtl/mips_stim_ctrl_pkg.sv
// Shared types and width helpers for the MIPS stimulus/control harness.
package mips_stim_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int calc_ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Width of a counter that must hold every value 0..n inclusive.
   function automatic int calc_cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/mips_irq_channel.sv
// One periodic interrupt channel: period register, phase counter and sticky irq bit.
module mips_irq_channel #(
   parameter int PERIOD_W = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_clr,
   input  logic                i_run,
   input  logic                i_we,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic                i_ack,
   output logic                o_irq
);

   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_phase;
   logic                r_irq;
   logic                w_active;
   logic                w_wrap;
   logic                w_fire;

   assign w_active = (r_period != '0);
   assign w_wrap   = (r_phase == r_period - PERIOD_W'(1));
   // A config write restarts the phase, so the old phase cannot fire that cycle.
   assign w_fire   = i_run && !i_we && w_active && w_wrap;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_period <= '0;
         r_phase  <= '0;
         r_irq    <= 1'b0;
      end else begin
         if (i_we) r_period <= i_period;
         if (i_clr) begin
            r_phase <= '0;
            r_irq   <= 1'b0;
         end else begin
            if (i_we)
               r_phase <= '0;
            else if (i_run && w_active)
               r_phase <= w_wrap ? '0 : r_phase + PERIOD_W'(1);
            if (i_run) r_irq <= w_fire | (r_irq & ~i_ack);
         end
      end
   end

   assign o_irq = r_irq;

endmodule

// File: rtl/mips_stim_ctrl.sv
// Stimulus/control harness for the MIPS core: reset sequencing, periodic
// interrupts, cycle counting and end-of-run detection (PC halt or timeout).
module mips_stim_ctrl
   import mips_stim_ctrl_pkg::*;
#(
   parameter  int N_IRQ       = 6,
   parameter  int RST_CYCLES  = 8,
   parameter  int PERIOD_W    = 16,
   parameter  int TIMEOUT     = 100000,
   parameter  int STALL_LIMIT = 64,
   localparam int CH_W        = calc_ch_w(N_IRQ)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_cfg_we,
   input  logic [CH_W-1:0]     i_cfg_ch,
   input  logic [PERIOD_W-1:0] i_cfg_period,
   input  logic [N_IRQ-1:0]    i_irq_ack,
   input  logic [31:0]         i_pc_in,
   input  logic                i_pc_valid,
   output logic                o_cpu_reset,
   output logic [N_IRQ-1:0]    o_irq,
   output logic [31:0]         o_cycle_cnt,
   output logic                o_done,
   output logic                o_timeout
);

   localparam int                 RST_W      = calc_cnt_w(RST_CYCLES);
   localparam int                 STALL_W    = calc_cnt_w(STALL_LIMIT);
   localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
   localparam logic [31:0]        CYC_LAST   = 32'(TIMEOUT - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [RST_W-1:0]   r_rst_cnt;
   logic [31:0]        r_cycle_cnt;
   logic [STALL_W-1:0] r_stall_cnt;
   logic [31:0]        r_last_pc;
   logic               r_last_vld;
   logic               r_done;
   logic               r_timeout;
   logic               r_cpu_reset;
   logic               w_restart;
   logic               w_run;
   logic               w_pc_same;
   logic [STALL_W-1:0] w_stall_nxt;
   logic [31:0]        w_cycle_nxt;
   logic               w_halt;
   logic               w_tmo;
   logic [N_IRQ-1:0]   w_irq;

   assign w_restart   = i_start && (r_state != ST_RST);
   assign w_run       = (r_state == ST_RUN);
   assign w_pc_same   = r_last_vld && (i_pc_in == r_last_pc);
   assign w_stall_nxt = !i_pc_valid ? r_stall_cnt :
                        w_pc_same   ? r_stall_cnt + STALL_W'(1) : '0;
   assign w_cycle_nxt = r_cycle_cnt + 32'd1;
   assign w_halt      = (w_stall_nxt == STALL_LAST);
   assign w_tmo       = (w_cycle_nxt == CYC_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= ST_RST;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_RST:  if (r_rst_cnt == RST_LAST) w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (i_start)               w_state_nxt = ST_RST;
            else if (w_halt || w_tmo)  w_state_nxt = ST_DONE;
         end
         ST_DONE: if (i_start) w_state_nxt = ST_RST;
         default: w_state_nxt = ST_RST;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_rst_cnt   <= '0;
         r_cycle_cnt <= '0;
         r_stall_cnt <= '0;
         r_last_pc   <= '0;
         r_last_vld  <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_cpu_reset <= 1'b1;
      end else begin
         r_cpu_reset <= (w_state_nxt == ST_RST);
         if (w_restart) begin
            r_rst_cnt   <= '0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_last_vld  <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
         end else if (r_state == ST_RST) begin
            r_rst_cnt <= r_rst_cnt + RST_W'(1);
         end else if (r_state == ST_RUN) begin
            r_cycle_cnt <= w_cycle_nxt;
            r_stall_cnt <= w_stall_nxt;
            if (i_pc_valid) begin
               r_last_pc  <= i_pc_in;
               r_last_vld <= 1'b1;
            end
            // Halt takes precedence when both end conditions land together.
            if (w_halt || w_tmo) begin
               r_done    <= 1'b1;
               r_timeout <= !w_halt;
            end
         end
      end
   end

   for (genvar g = 0; g < N_IRQ; g++) begin : g_ch
      mips_irq_channel #(.PERIOD_W(PERIOD_W)) u_ch (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_clr    (w_restart),
         .i_run    (w_run),
         .i_we     (i_cfg_we && (i_cfg_ch == CH_W'(g))),
         .i_period (i_cfg_period),
         .i_ack    (i_irq_ack[g]),
         .o_irq    (w_irq[g])
      );
   end

   assign o_cpu_reset = r_cpu_reset;
   assign o_irq       = w_irq;
   assign o_cycle_cnt = r_cycle_cnt;
   assign o_done      = r_done;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_mips_stim_ctrl.sv
// Bench for mips_stim_ctrl: directed scenarios plus randomized runs, each cycle
// compared against a behavioural model of the harness.
module tb_mips_stim_ctrl;

   localparam int N_IRQ       = 6;
   localparam int RST_CYCLES  = 8;
   localparam int PERIOD_W    = 16;
   localparam int TIMEOUT     = 50;
   localparam int STALL_LIMIT = 16;
   localparam int CH_W        = 3;

   logic                clk = 1'b0;
   logic                reset, start, cfg_we, pc_valid;
   logic [CH_W-1:0]     cfg_ch;
   logic [PERIOD_W-1:0] cfg_period;
   logic [N_IRQ-1:0]    irq_ack;
   logic [31:0]         pc_in;
   logic                cpu_reset, done, timeout;
   logic [N_IRQ-1:0]    irq;
   logic [31:0]         cycle_cnt;

   int n_checks = 0;
   int n_err    = 0;
   bit auto_pc  = 1'b0;

   // model: mode 0 = holding core in reset, 1 = running, 2 = finished
   int               m_mode;
   int               m_rst_n;
   int unsigned      m_cyc;
   logic [N_IRQ-1:0] m_irq;
   bit               m_done, m_tmo;
   int               m_per [N_IRQ];
   int               m_age [N_IRQ];
   bit               m_has;
   logic [31:0]      m_last;
   int               m_rep;

   int n, t, last_rise, rises;
   logic prev;

   always #5 clk = ~clk;

   mips_stim_ctrl #(
      .N_IRQ(N_IRQ), .RST_CYCLES(RST_CYCLES), .PERIOD_W(PERIOD_W),
      .TIMEOUT(TIMEOUT), .STALL_LIMIT(STALL_LIMIT)
   ) u_dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_cfg_we(cfg_we),
      .i_cfg_ch(cfg_ch), .i_cfg_period(cfg_period), .i_irq_ack(irq_ack),
      .i_pc_in(pc_in), .i_pc_valid(pc_valid), .o_cpu_reset(cpu_reset),
      .o_irq(irq), .o_cycle_cnt(cycle_cnt), .o_done(done), .o_timeout(timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear_run();
      m_mode = 0; m_rst_n = 0; m_cyc = 0; m_irq = '0;
      m_done = 0; m_tmo = 0; m_has = 0; m_rep = 0;
      for (int c = 0; c < N_IRQ; c++) m_age[c] = 0;
   endtask

   task automatic model_edge();
      bit restart, run, we_c, fire;
      if (!reset) begin
         model_clear_run();
         for (int c = 0; c < N_IRQ; c++) m_per[c] = 0;
         return;
      end
      restart = start && (m_mode != 0);
      run     = (m_mode == 1) && !restart;
      for (int c = 0; c < N_IRQ; c++) begin
         we_c = cfg_we && (int'(cfg_ch) == c);
         if (run) begin
            fire = (m_per[c] != 0) && !we_c && ((m_age[c] + 1) % m_per[c] == 0);
            m_irq[c] = fire | (m_irq[c] & !irq_ack[c]);
            if (we_c) m_age[c] = 0;
            else if (m_per[c] != 0) m_age[c]++;
         end else if (we_c) begin
            m_age[c] = 0;
         end
      end
      if (restart) model_clear_run();
      else if (m_mode == 0) begin
         m_rst_n++;
         if (m_rst_n == RST_CYCLES) m_mode = 1;
      end else if (m_mode == 1) begin
         m_cyc++;
         if (pc_valid) begin
            if (m_has && pc_in == m_last) m_rep++;
            else m_rep = 0;
            m_last = pc_in;
            m_has  = 1;
         end
         if (m_rep == STALL_LIMIT - 1) begin
            m_mode = 2; m_done = 1; m_tmo = 0;
         end else if (m_cyc == TIMEOUT - 1) begin
            m_mode = 2; m_done = 1; m_tmo = 1;
         end
      end
      if (cfg_we && int'(cfg_ch) < N_IRQ) m_per[cfg_ch] = int'(cfg_period);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      if (auto_pc) pc_in = pc_in + 32'd4;
      chk("cpu_reset", cpu_reset, 32'(m_mode == 0));
      chk("irq",       irq,       m_irq);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("done",      done,      m_done);
      chk("timeout",   timeout,   m_tmo);
   endtask

   task automatic cfg(input int ch, input int p);
      cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_period = PERIOD_W'(p);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic restart();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (RST_CYCLES) tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear_run();
      for (int c = 0; c < N_IRQ; c++) m_per[c] = 0;
      m_last = '0;
      reset = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
      irq_ack = '0; pc_in = 32'h1000; pc_valid = 1'b1; auto_pc = 1'b1;

      // reset sequencing
      repeat (3) tick();
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_irq", irq, 0);
      reset = 1'b1;
      n = 0;
      while (cpu_reset === 1'b1 && n < 20) begin n++; tick(); end
      chk("rst_len", n, RST_CYCLES);
      chk("run_cycle0", cycle_cnt, 0);

      // periodic irq on ch2, never acked
      cfg(2, 5);
      n = 0;
      while (irq[2] !== 1'b1 && n < 20) begin n++; tick(); end
      chk("irq2_delay", n, 5);
      repeat (8) begin tick(); chk("irq2_sticky", irq[2], 1); end

      // ack one cycle after each rise: pulses every 5 cycles
      prev = irq[2]; last_rise = -1; rises = 0;
      for (t = 1; t <= 17; t++) begin
         irq_ack[2] = irq[2];
         tick();
         if (irq[2] && !prev) begin
            if (last_rise >= 0) chk("irq2_gap", t - last_rise, 5);
            last_rise = t;
            rises++;
         end
         prev = irq[2];
      end
      chk("irq2_rises", 32'(rises >= 3), 1);
      irq_ack = '0;
      restart();

      // set/ack collision at period 1, then an out-of-range channel write
      cfg(2, 0);
      cfg(0, 1);
      irq_ack[0] = 1'b1;
      repeat (10) begin tick(); chk("collide_irq0", irq[0], 1); end
      irq_ack = '0;
      cfg(7, 3);
      repeat (4) tick();
      restart();

      // randomized runs
      auto_pc = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 40; k++) begin
            cfg_we     = ($urandom_range(0, 5) == 0);
            cfg_ch     = CH_W'($urandom_range(0, 7));
            cfg_period = PERIOD_W'($urandom_range(0, 7));
            irq_ack    = N_IRQ'($urandom & $urandom);
            pc_valid   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) pc_in = $urandom;
            tick();
         end
         cfg_we = 1'b0; irq_ack = '0; pc_valid = 1'b1;
         restart();
      end

      // halt on a held PC
      pc_in = 32'h3000; tick();
      pc_in = 32'h3004; tick();
      pc_in = 32'h3008; tick();
      n = 0;
      while (done !== 1'b1 && n < 40) begin n++; tick(); end
      chk("halt_done", done, 1);
      chk("halt_timeout", timeout, 0);
      chk("halt_cycles", cycle_cnt, 3 + STALL_LIMIT - 1);
      pc_in = 32'h4000; auto_pc = 1'b1;
      irq_ack = '1;
      repeat (5) tick();
      irq_ack = '0;
      chk("halt_frozen", cycle_cnt, 3 + STALL_LIMIT - 1);

      // restart from DONE keeps periods
      cfg(5, 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (cpu_reset === 1'b1 && n < 20) begin n++; tick(); end
      chk("restart_len", n, RST_CYCLES);
      n = 0;
      while (irq[5] !== 1'b1 && n < 10) begin n++; tick(); end
      chk("kept_period5", n, 3);

      // timeout with PC always changing
      n = 0;
      while (done !== 1'b1 && n < 100) begin n++; tick(); end
      chk("tmo_done", done, 1);
      chk("tmo_flag", timeout, 1);
      chk("tmo_cycles", cycle_cnt, TIMEOUT - 1);

      // mid-run reset clears everything including periods
      restart();
      repeat (5) tick();
      reset = 1'b0;
      tick();
      chk("midrst_cpu_reset", cpu_reset, 1);
      chk("midrst_irq", irq, 0);
      chk("midrst_cycles", cycle_cnt, 0);
      chk("midrst_done", done, 0);
      reset = 1'b1;
      repeat (RST_CYCLES) tick();
      repeat (12) begin tick(); chk("no_irq_after_reset", irq, 0); end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
